// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: producer request, synchronized read pointer,
// memory write port and status flags.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
) ();
  localparam int P = ADDR_WIDTH + 1;

  logic                  winc;
  logic [P-1:0]          rq_sync;
  logic                  ovf_clr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wclken;
  logic [P-1:0]          wptr_gray;
  logic                  wfull;
  logic                  wafull;
  logic [P-1:0]          wlevel;
  logic                  wovf;

  // Producer / environment side.
  modport master (
    output winc, rq_sync, ovf_clr,
    input  waddr, wclken, wptr_gray, wfull, wafull, wlevel, wovf
  );

  // Write controller side.
  modport slave (
    input  winc, rq_sync, ovf_clr,
    output waddr, wclken, wptr_gray, wfull, wafull, wlevel, wovf
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of an async FIFO: binary/Gray write pointers, full,
// almost-full, occupancy estimate and sticky overflow.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int AFULL_LEVEL = 6
) (
  input logic           clk,
  input logic           rst,
  fifo_wr_ctrl_if.slave bus
);
  localparam int P = ADDR_WIDTH + 1;
  localparam logic [P-1:0] ONE_P   = {{(P-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] AFULL_P = P'(AFULL_LEVEL);

  logic [P-1:0] wbin_r;
  logic [P-1:0] wgray_r;
  logic         wfull_r;
  logic         wafull_r;
  logic [P-1:0] wlevel_r;
  logic         wovf_r;

  logic         accept_s;
  logic         blocked_s;
  logic [P-1:0] wbin_next_s;
  logic [P-1:0] wgray_next_s;
  logic [P-1:0] rq_full_s;
  logic         full_next_s;
  logic [P-1:0] level_next_s;
  logic         afull_next_s;
  logic         ovf_next_s;

  function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
    logic [P-1:0] b;
    b[P-1] = g[P-1];
    for (int i = P - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state pointer, flag and occupancy computation.
  always_comb begin
    accept_s  = bus.winc & ~wfull_r;
    blocked_s = bus.winc & wfull_r;
    if (accept_s) begin
      wbin_next_s = wbin_r + ONE_P;
    end else begin
      wbin_next_s = wbin_r;
    end
    wgray_next_s = (wbin_next_s >> 1) ^ wbin_next_s;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    rq_full_s    = {~bus.rq_sync[P-1:P-2], bus.rq_sync[P-3:0]};
    full_next_s  = (wgray_next_s == rq_full_s);
    level_next_s = wbin_next_s - gray2bin(bus.rq_sync);
    afull_next_s = (level_next_s >= AFULL_P);
    if (blocked_s) begin
      ovf_next_s = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = wovf_r;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_r   <= {P{1'b0}};
      wgray_r  <= {P{1'b0}};
      wfull_r  <= 1'b0;
      wafull_r <= 1'b0;
      wlevel_r <= {P{1'b0}};
      wovf_r   <= 1'b0;
    end else begin
      wbin_r   <= wbin_next_s;
      wgray_r  <= wgray_next_s;
      wfull_r  <= full_next_s;
      wafull_r <= afull_next_s;
      wlevel_r <= level_next_s;
      wovf_r   <= ovf_next_s;
    end
  end

  // The write strobe is gated by reset so nothing reaches memory while rst is low.
  assign bus.wclken    = accept_s & rst;
  assign bus.waddr     = wbin_r[ADDR_WIDTH-1:0];
  assign bus.wptr_gray = wgray_r;
  assign bus.wfull     = wfull_r;
  assign bus.wafull    = wafull_r;
  assign bus.wlevel    = wlevel_r;
  assign bus.wovf      = wovf_r;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus randomized traffic
// against an occupancy-count reference model.
module tb_fifo_wr_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int PMOD  = 16;
  localparam int AFULL = 6;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  // Reference model: total accepted writes, read count, last flags.
  int   wr_total;
  int   r_int;
  int   occ;
  logic m_full;
  logic m_ovf;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] bin2gray(input int v);
    logic [3:0] b;
    b = 4'(v % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_waddr"},  32'(bus.waddr),     32'd0);
    check_val({tag, "_wclken"}, 32'(bus.wclken),    32'd0);
    check_val({tag, "_wgray"},  32'(bus.wptr_gray), 32'd0);
    check_val({tag, "_wfull"},  32'(bus.wfull),     32'd0);
    check_val({tag, "_wafull"}, 32'(bus.wafull),    32'd0);
    check_val({tag, "_wlevel"}, 32'(bus.wlevel),    32'd0);
    check_val({tag, "_wovf"},   32'(bus.wovf),      32'd0);
  endtask

  task automatic model_reset();
    wr_total = 0;
    r_int    = 0;
    occ      = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic w, input logic clr, input int r);
    logic [3:0] g_prev;
    r_int       = r;
    bus.winc    = w;
    bus.ovf_clr = clr;
    bus.rq_sync = bin2gray(r);
    #1;
    check_val("wclken", 32'(bus.wclken), 32'(w && !m_full));
    check_val("waddr_pre", 32'(bus.waddr), 32'(wr_total % DEPTH));
    g_prev = bus.wptr_gray;
    if (w && m_full) begin
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    if (w && !m_full) wr_total++;
    occ    = wr_total - r;
    m_full = (occ == DEPTH);
    @(posedge clk);
    #1;
    check_val("wptr_gray", 32'(bus.wptr_gray), 32'(bin2gray(wr_total)));
    check_val("gray_1bit", 32'($countones(g_prev ^ bus.wptr_gray) <= 1), 32'd1);
    check_val("wfull",  32'(bus.wfull),  32'(m_full));
    check_val("wlevel", 32'(bus.wlevel), 32'(occ));
    check_val("wafull", 32'(bus.wafull), 32'(occ >= AFULL));
    check_val("wovf",   32'(bus.wovf),   32'(m_ovf));
    check_val("waddr",  32'(bus.waddr),  32'(wr_total % DEPTH));
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset between edges, releases at a later falling edge.
  task automatic do_reset(input logic w);
    rst         = 1'b0;
    bus.winc    = w;
    bus.ovf_clr = 1'b0;
    bus.rq_sync = 4'b0000;
    #1;
    check_zero("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int rd_pct;
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b0;
    bus.winc    = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.rq_sync = 4'b0000;
    model_reset();
    #2;
    check_zero("init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fill to full with no reads.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0);
    check_val("fill_gray", 32'(bus.wptr_gray), 32'hC);
    check_val("fill_full", 32'(bus.wfull), 32'd1);

    // Overflow then clear.
    step(1'b1, 1'b0, 0);
    check_val("ovf_set", 32'(bus.wovf), 32'd1);
    check_val("ovf_addr", 32'(bus.waddr), 32'd0);
    step(1'b0, 1'b1, 0);
    check_val("ovf_clr", 32'(bus.wovf), 32'd0);

    // One read releases full; next write accepted.
    step(1'b0, 1'b0, 1);
    check_val("drain_level", 32'(bus.wlevel), 32'd7);
    step(1'b1, 1'b0, 1);

    // Blocked write, clear and read advance in the same cycle.
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 2);
    check_val("simul_ovf", 32'(bus.wovf), 32'd1);
    check_val("simul_full", 32'(bus.wfull), 32'd0);

    // Reset asserted mid-burst after 5 writes.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    do_reset(1'b1);
    step(1'b1, 1'b0, 0);

    // Wrap with the read pointer trailing three writes behind.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, (wr_total >= 3) ? wr_total - 3 : 0);
      if (i == 14) check_val("wrap_gray15", 32'(bus.wptr_gray), 32'h8);
      if (i == 15) check_val("wrap_gray0", 32'(bus.wptr_gray), 32'h0);
    end

    // Randomized traffic with alternating read pressure.
    for (int i = 0; i < 2000; i++) begin
      int r_next;
      rd_pct = ((i / 250) % 2 == 1) ? 70 : 25;
      r_next = r_int;
      if ((wr_total > r_int) && ($urandom_range(0, 99) < rd_pct)) r_next = r_int + 1;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), r_next);
      if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: FIFO memory address width. Depth DEPTH = 2^ADDR_WIDTH; pointer width P = ADDR_WIDTH+1.
REQ-002 Parameter AFULL_LEVEL, default 6: occupancy threshold for almost-full, legal range 1..DEPTH-1.
REQ-003 Port clk, input, 1: write-domain clock; all state is updated on the rising edge.
REQ-004 Port rst, input, 1: asynchronous active-low reset.
REQ-005 Port winc, input, 1: write request from the producer.
REQ-006 Port rq2_wptr... name rq_sync, input, P: read pointer, Gray-coded, already synchronized into the clk domain by the two-stage synchronizer.
REQ-007 Port ovf_clr, input, 1: synchronous clear of the sticky overflow flag.
REQ-008 Port waddr, output, ADDR_WIDTH: memory write address.
REQ-009 Port wclken, output, 1: memory write enable.
REQ-010 Port wptr_gray, output, P: registered Gray write pointer, fed to the read-domain synchronizer.
REQ-011 Port wfull, output, 1: FIFO full.
REQ-012 Port wafull, output, 1: almost full.
REQ-013 Port wlevel, output, P: estimated occupancy, 0..DEPTH.
REQ-014 Port wovf, output, 1: sticky overflow, meaning a write was attempted while full.

Function
REQ-015 Internal binary counter wbin, P bits.
  - Write accepted when winc=1 and wfull=0.
  - On acceptance, wbin <= wbin+1 modulo 2^P, wrapping from 2^P-1 to 0.
  - Otherwise wbin holds.
REQ-016 waddr = wbin[ADDR_WIDTH-1:0], taken directly from the register with no added latency.
REQ-017 wclken = winc & ~wfull, combinational.
  - The memory write occurs in the same cycle as acceptance.
REQ-018 Next pointer values:
  - wbin_next = wbin+1 on acceptance, else wbin.
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - wptr_gray <= wgray_next every cycle, so it changes by at most one bit per cycle.
REQ-019 wfull is registered and recomputed every cycle: wfull <= (wgray_next == {~rq_sync[P-1:P-2], rq_sync[P-3:0]}).
  - Full asserts in the cycle after the DEPTH-th unread write.
  - Full deasserts one cycle after rq_sync advances.
REQ-020 Occupancy: wlevel <= (wbin_next - gray2bin(rq_sync)) modulo 2^P, registered.
  - gray2bin is XOR-prefix decode, MSB first.
REQ-021 wafull <= (level_next >= AFULL_LEVEL), where level_next is the value loaded into wlevel the same cycle.
REQ-022 Write attempted while full (winc=1, wfull=1):
  - no pointer change;
  - wclken=0;
  - wovf <= 1 at the next edge.
REQ-023 wovf holds 1 until ovf_clr=1 at an edge.
  - If set and clear coincide in the same cycle, set wins.
REQ-024 Because rq_sync lags the true read pointer, wfull and wlevel are pessimistic. The block never reports less occupancy than is actually present.

Reset
REQ-025 On rst=0, asynchronously and regardless of clk, all of the following go to 0 immediately:
  - wbin, wptr_gray, waddr;
  - wfull, wafull, wlevel, wovf.
REQ-026 wclken = 0 while wfull... while rst=0, wclken is forced to 0.
REQ-027 Reset release is synchronous to clk. The first write is accepted at the first rising edge with rst=1 and winc=1.
REQ-028 Reset asserted mid-burst:
  - the in-flight write is discarded;
  - no partial pointer update is visible.

Verification
REQ-029 Fill. After reset, hold rq_sync=0000 and apply winc=1 for 8 cycles.
  - waddr steps 0..7, wclken=1 throughout.
  - wlevel steps 1..8; wafull=1 from wlevel=6.
  - wptr_gray=1100 and wfull=1 after the 8th edge.
REQ-030 Overflow. From full, apply a 9th winc.
  - wclken=0, waddr stays 0, wptr_gray stays 1100.
  - wovf=1 next cycle.
  - ovf_clr pulse -> wovf=0.
REQ-031 Drain release. From full, set rq_sync=0001 (one read).
  - wfull=0 and wlevel=7 one cycle later; the next winc is accepted.
REQ-032 Wrap. Write 16 entries with rq_sync tracking wptr_gray 3 cycles late.
  - wbin wraps 1111 -> 0000.
  - wptr_gray goes 1000 -> 0000.
  - wfull never asserts; every step changes exactly one bit.
REQ-033 Mid-operation reset. Drive rst=0 between clock edges after 5 writes.
  - All outputs are 0 before the next edge.
  - After release, the first write uses waddr=0.
REQ-034 Simultaneous events. In the same cycle, a write is blocked by full, ovf_clr=1, and rq_sync advances.
  - wovf=1 (set wins).
  - wfull=0 next cycle.
